// File: rtl/fs_pkg.sv
// rtl/fs_pkg.sv - shared entry type and constants for the forwarding scoreboard
package fs_pkg;
  // Widest channel tag an entry can hold; covers NREG up to 256.
  localparam int FS_TAG_MAX = 8;
  localparam logic [FS_TAG_MAX-1:0] CH_NONE = '0;

  typedef struct packed {
    logic                  valid;
    logic [FS_TAG_MAX-1:0] dst;
    logic                  late;
  } fs_entry_t;

  localparam fs_entry_t ENTRY_BUBBLE = '{valid: 1'b0, dst: CH_NONE, late: 1'b0};
endpackage

// File: rtl/fs_src_select.sv
// rtl/fs_src_select.sv - youngest-match search and readiness check for one source operand
module fs_src_select
  import fs_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 16,
  parameter int NSTAGE   = 3,
  parameter int LATE_STG = 1,
  localparam int TAG_W   = $clog2(NREG)
) (
  input  fs_entry_t [NSTAGE-1:0]      entries,
  input  logic [TAG_W-1:0]            src_ch,
  input  logic [NSTAGE*XLEN-1:0]      stg_data,
  input  logic [NREG-1:0]             fwd_block,
  output logic                        hit,
  output logic                        ready,
  output logic [XLEN-1:0]             fwd_data
);

  logic blocked;

  always_comb begin
    hit      = 1'b0;
    ready    = 1'b0;
    fwd_data = '0;
    blocked  = (src_ch == '0) || fwd_block[src_ch];
    // Walk oldest to youngest so the lowest stage index wins.
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (!blocked && entries[k].valid && entries[k].dst == FS_TAG_MAX'(src_ch)) begin
        hit      = 1'b1;
        ready    = !entries[k].late || (k >= LATE_STG);
        fwd_data = stg_data[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - in-flight destination tracker with operand forwarding and load-use stall
module forward_scoreboard
  import fs_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 16,
  parameter int NSTAGE   = 3,
  parameter int NSRC     = 2,
  parameter int LATE_STG = 1,
  localparam int TAG_W   = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [TAG_W-1:0]         issue_dst,
  input  logic                     issue_late,
  output logic                     issue_ready,
  input  logic [NSRC*TAG_W-1:0]    src_ch,
  input  logic [NSRC*XLEN-1:0]     src_reg_data,
  output logic [NSRC*XLEN-1:0]     src_data,
  input  logic [NSTAGE*XLEN-1:0]   stg_data,
  input  logic [NREG-1:0]          fwd_block,
  input  logic                     flush,
  output logic [15:0]              stall_cnt
);

  fs_entry_t [NSTAGE-1:0]  pipe;
  logic [NSRC-1:0]         hit;
  logic [NSRC-1:0]         rdy;
  logic [NSRC*XLEN-1:0]    fwd;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fs_src_select #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .NSTAGE   (NSTAGE),
      .LATE_STG (LATE_STG)
    ) u_sel (
      .entries   (pipe),
      .src_ch    (src_ch[s*TAG_W +: TAG_W]),
      .stg_data  (stg_data),
      .fwd_block (fwd_block),
      .hit       (hit[s]),
      .ready     (rdy[s]),
      .fwd_data  (fwd[s*XLEN +: XLEN])
    );
  end

  assign issue_ready = !(issue_valid && |(hit & ~rdy));

  // A stalled issue sees plain register-file data on every source.
  always_comb begin
    src_data = src_reg_data;
    for (int s = 0; s < NSRC; s++) begin
      if (issue_ready && hit[s] && rdy[s])
        src_data[s*XLEN +: XLEN] = fwd[s*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) pipe[k] <= ENTRY_BUBBLE;
      stall_cnt <= '0;
    end else begin
      if (flush || !(issue_valid && issue_ready))
        pipe[0] <= ENTRY_BUBBLE;
      else
        pipe[0] <= '{valid: 1'b1, dst: FS_TAG_MAX'(issue_dst), late: issue_late};
      for (int k = 1; k < NSTAGE; k++)
        pipe[k] <= flush ? ENTRY_BUBBLE : pipe[k-1];
      if (issue_valid && !issue_ready && !flush && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - directed checks of forwarding, stalls, flush and reset
module tb_forward_scoreboard;

  localparam logic [31:0] R0 = 32'hAAAA0000;
  localparam logic [31:0] R1 = 32'hBBBB0001;
  localparam logic [31:0] S0 = 32'h11111111;
  localparam logic [31:0] S1 = 32'h22222222;
  localparam logic [31:0] S2 = 32'h33333333;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [3:0]  issue_dst;
  logic        issue_late;
  logic        issue_ready;
  logic [7:0]  src_ch;
  logic [63:0] src_reg_data;
  logic [63:0] src_data;
  logic [95:0] stg_data;
  logic [15:0] fwd_block;
  logic        flush;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  forward_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_dst    (issue_dst),
    .issue_late   (issue_late),
    .issue_ready  (issue_ready),
    .src_ch       (src_ch),
    .src_reg_data (src_reg_data),
    .src_data     (src_data),
    .stg_data     (stg_data),
    .fwd_block    (fwd_block),
    .flush        (flush),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then let them settle.
  task automatic cyc(input logic v, input logic [3:0] d, input logic l,
                     input logic [3:0] s0, input logic [3:0] s1, input logic f);
    @(negedge clk);
    issue_valid = v;
    issue_dst   = d;
    issue_late  = l;
    src_ch      = {s1, s0};
    flush       = f;
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    issue_valid  = 1'b1;
    issue_dst    = 4'd0;
    issue_late   = 1'b0;
    src_ch       = {4'd3, 4'd3};
    src_reg_data = {R1, R0};
    stg_data     = {S2, S1, S0};
    fwd_block    = '0;
    flush        = 1'b0;

    @(negedge clk);
    #1;
    check("rst_ready", {31'd0, issue_ready}, 32'd1);
    check("rst_src0", src_data[31:0], R0);
    check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    rst_n = 1'b1;

    // Back-to-back dependency forwards from stage 0.
    cyc(1, 4'd3, 0, 4'd0, 4'd0, 0);
    cyc(1, 4'd0, 0, 4'd3, 4'd0, 0);
    check("fwd_s0_data", src_data[31:0], S0);
    check("fwd_s0_ready", {31'd0, issue_ready}, 32'd1);
    check("fwd_src1_none", src_data[63:32], R1);
    cyc(0, 4'd0, 0, 4'd0, 4'd0, 1);

    // Two writers of ch3 in flight: the youngest wins.
    cyc(1, 4'd3, 0, 4'd0, 4'd0, 0);
    cyc(1, 4'd0, 0, 4'd0, 4'd0, 0);
    cyc(1, 4'd3, 0, 4'd0, 4'd0, 0);
    cyc(1, 4'd0, 0, 4'd3, 4'd3, 0);
    check("youngest_src0", src_data[31:0], S0);
    check("youngest_src1", src_data[63:32], S0);
    cyc(1, 4'd0, 0, 4'd3, 4'd0, 0);
    check("fwd_stage1", src_data[31:0], S1);
    cyc(1, 4'd0, 0, 4'd3, 4'd0, 0);
    check("fwd_stage2", src_data[31:0], S2);
    cyc(0, 4'd0, 0, 4'd0, 4'd0, 1);

    // Load-use: one stall cycle, then forward from stage 1.
    cyc(1, 4'd5, 1, 4'd0, 4'd0, 0);
    cyc(1, 4'd0, 0, 4'd5, 4'd0, 0);
    check("lu_stall", {31'd0, issue_ready}, 32'd0);
    check("lu_stall_data", src_data[31:0], R0);
    cyc(1, 4'd0, 0, 4'd5, 4'd0, 0);
    check("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    check("lu_ready", {31'd0, issue_ready}, 32'd1);
    check("lu_data", src_data[31:0], S1);
    cyc(0, 4'd0, 0, 4'd0, 4'd0, 1);

    // Blocked channel reads the register file.
    fwd_block = 16'h4000;
    cyc(1, 4'd14, 0, 4'd0, 4'd0, 0);
    cyc(1, 4'd0, 0, 4'd14, 4'd14, 0);
    check("blk_src0", src_data[31:0], R0);
    check("blk_src1", src_data[63:32], R1);
    check("blk_ready", {31'd0, issue_ready}, 32'd1);
    fwd_block = '0;
    cyc(0, 4'd0, 0, 4'd0, 4'd0, 1);

    // Flush kills the late entry and the same-cycle issue.
    cyc(1, 4'd5, 1, 4'd0, 4'd0, 0);
    cyc(1, 4'd6, 0, 4'd5, 4'd0, 1);
    check("fl_ready_same", {31'd0, issue_ready}, 32'd0);
    cyc(1, 4'd0, 0, 4'd5, 4'd6, 0);
    check("fl_ready", {31'd0, issue_ready}, 32'd1);
    check("fl_src0", src_data[31:0], R0);
    check("fl_src1", src_data[63:32], R1);
    check("fl_cnt", {16'd0, stall_cnt}, 32'd1);

    // Reset during a stall drops the hazard at once.
    cyc(1, 4'd5, 1, 4'd0, 4'd0, 0);
    cyc(1, 4'd0, 0, 4'd5, 4'd0, 0);
    check("mr_stall", {31'd0, issue_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mr_ready", {31'd0, issue_ready}, 32'd1);
    check("mr_cnt", {16'd0, stall_cnt}, 32'd0);
    check("mr_src0", src_data[31:0], R0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_after", {31'd0, issue_ready}, 32'd1);

    // Saturation from a preset count.
    cyc(1, 4'd5, 1, 4'd0, 4'd0, 0);
    force dut.stall_cnt = 16'hFFFE;
    #1 release dut.stall_cnt;
    #1;
    check("sat_preset", {16'd0, stall_cnt}, 32'h0000FFFE);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 4'd5, 1, 4'd5, 4'd0, 0);
      check("sat_ready", {31'd0, issue_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i > 0) check("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    end
    cyc(0, 4'd0, 0, 4'd0, 4'd0, 0);
    check("sat_final", {16'd0, stall_cnt}, 32'h0000FFFF);
    #1 rst_n = 1'b0;
    #1;
    check("sat_rst", {16'd0, stall_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
